ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master arbiter and sequencer for the single-port data RAM behind the memory/IO controller. Master 0 is the CPU data path (load/store) and master 1 is a DMA/program-loader port. The block serialises their requests onto one synchronous RAM port using fair round-robin arbitration and a req/ack handshake. Master 0's stall is derived from that handshake.

## Interface
- `AW`, default 32: address width (`RegBus`).
- `DW`, default 32: data width (`RegBus`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `m0_req` / `m1_req`  in  1  access request; held until the matching ack.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  AW  byte address.
- `m0_wdata` / `m1_wdata`  in  DW  write data.
- `m0_sel` / `m1_sel`  in  4  byte-lane enables.
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata` / `m1_rdata`  out  DW  read data; valid only while the matching ack is high, otherwise 0.
- `m0_stall`  out  1  `m0_req & ~m0_ack`; freezes the CPU pipeline.
- `ram_ce_o`  out  1  RAM chip enable.
- `ram_we_o`  out  1  RAM write enable.
- `ram_addr_o`  out  AW  RAM address.
- `ram_data_o`  out  DW  RAM write data.
- `ram_sel_o`  out  4  RAM byte enables.
- `ram_data_i`  in  DW  RAM read data; registered, valid the cycle after `ram_ce_o`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Any request present: capture the winner's we/addr/wdata/sel and master id into registers, then go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS**
  - `ram_ce_o` = 1.
  - `ram_we_o`, `ram_addr_o`, `ram_data_o`, `ram_sel_o` come from the captured registers.
  - Always go to RESP.
- **RESP**
  - Assert the granted master's ack.
  - Its rdata = `ram_data_i` for reads, 0 for writes.
  - The granted master's req is ignored this cycle.
  - If the other master requests: capture it and go directly to ACCESS.
  - Otherwise: go to IDLE.
- **Arbitration**
  - Round-robin. The `last` register holds the id of the most recent grant.
  - On a tie, the master that is not `last` wins.
  - `last` resets to 1, so master 0 wins the first tie.
  - `last` updates at each capture.
- All RAM outputs are combinational from state and captured registers, gated by `~rst`. Outside ACCESS they are all 0.
- A master changing addr/we/wdata while req is held has no effect after capture.
- A master dropping req before its ack is a protocol violation: its transaction still completes and acks.

## Timing
- **Reset values:** state IDLE, `last` = 1, and all of the following are 0:
  - acks, rdata, `m0_stall` (if `m0_req` is 0)
  - all `ram_*` outputs.
- `rst` high during ACCESS: `ram_ce_o`/`ram_we_o` are forced to 0 in that same cycle, so no write occurs. The FSM is IDLE next cycle.
- `rst` high during RESP: the ack is suppressed and the transaction is lost. The master re-requests.
- **Latency**, with req sampled in IDLE at edge N:
  - ACCESS occupies cycle N..N+1.
  - Ack is high in cycle N+1..N+2.
  - Minimum 2 cycles from req to ack.
- **Throughput:**
  - A single master holding req continuously gets one transaction per 3 cycles (IDLE, ACCESS, RESP).
  - Two contending masters alternate, one transaction per 2 cycles.
- **Starvation bound:** a waiting master is served within 4 cycles of the other's ack.
- `m0_stall` is combinational and drops in the ack cycle.

## Structure
- The state encodings (`ArbIdle` = 2'b00, `ArbAccess` = 2'b01, `ArbResp` = 2'b10) and the master ids go in `defines.v`, next to `RegBus`.
- A separate sub-module `rr_pick2` holds the two-request round-robin selector and `last` update. The main block holds the FSM, capture registers and output muxing.

## Test plan
- **Reset:** hold `rst` for 3 cycles with both reqs high → every output 0 except `m0_stall` = 1; no `ram_ce_o`.
- **m0 read:** read at 0x10 with RAM model word 0xDEADBEEF → `ram_ce_o` = 1, `ram_we_o` = 0, `ram_addr_o` = 0x10 one cycle after req; `m0_ack` = 1 and `m0_rdata` = 0xDEADBEEF the following cycle; `m0_stall` is 1 for 2 cycles.
- **m1 write then m0 read:** m1 writes 0x12345678 to 0x20 with sel 4'b0011, RAM preloaded with 0xFFFFFFFF; then m0 reads 0x20 → `m0_rdata` = 0xFFFF5678.
- **Simultaneous request after reset:** both req in the same cycle → m0 acks at cycle +2 and m1 acks at cycle +4, with no IDLE between them.
- **Continuous contention:** both reqs held for 12 cycles → acks alternate m0, m1, m0, m1..., 6 acks total, never two consecutive acks to the same master.
- **Reset mid-write:** assert `rst` during ACCESS of an m0 write of 0xA5A5A5A5 to 0x40 → `ram_we_o` = 0 that cycle, RAM[0x40] unchanged, no `m0_ack`, and outputs are at reset values next cycle.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared encodings for the data RAM arbiter
package ram_arbiter_pkg;

  localparam int REG_BUS = 32;

  typedef enum logic [1:0] {
    ArbIdle   = 2'b00,
    ArbAccess = 2'b01,
    ArbResp   = 2'b10
  } arb_state_e;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-request round-robin selector with last-grant memory
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_valid,
  output logic o_grant
);

  logic r_last;

  // On a tie the master that was not granted last wins; otherwise the sole requester.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = MASTER1;
    if (i_req0 && i_req1) begin
      o_grant = ~r_last;
    end else if (i_req0) begin
      o_grant = MASTER0;
    end
  end

  // Remember the most recent grant; starts at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= MASTER1;
    end else if (i_update && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master sequencer onto a single-port synchronous RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = REG_BUS,
  parameter int DW = REG_BUS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_sel,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_sel,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_data_o,
  output logic [3:0]    ram_sel_o,
  input  logic [DW-1:0] ram_data_i
);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_sel;

  logic w_resp;
  logic w_req0;
  logic w_req1;
  logic w_valid;
  logic w_grant;
  logic w_capture;

  // The master being acknowledged cannot win again in its own response cycle.
  assign w_resp    = (r_state == ArbResp);
  assign w_req0    = m0_req & ~(w_resp & (r_id == MASTER0));
  assign w_req1    = m1_req & ~(w_resp & (r_id == MASTER1));
  assign w_capture = ~rst & w_valid & ((r_state == ArbIdle) | w_resp);

  rr_pick2 u_pick (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .i_update (w_capture),
    .o_valid  (w_valid),
    .o_grant  (w_grant)
  );

  // State register; reset always returns to idle, abandoning any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ArbIdle;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the winner's request so later changes on its bus have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= MASTER0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (w_capture) begin
      r_id    <= w_grant;
      r_we    <= (w_grant == MASTER0) ? m0_we    : m1_we;
      r_addr  <= (w_grant == MASTER0) ? m0_addr  : m1_addr;
      r_wdata <= (w_grant == MASTER0) ? m0_wdata : m1_wdata;
      r_sel   <= (w_grant == MASTER0) ? m0_sel   : m1_sel;
    end
  end

  // Next state plus RAM strobes and acks; everything is forced low while reset is high.
  always_comb begin
    w_next     = r_state;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_sel_o  = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    case (r_state)
      ArbIdle: begin
        if (w_valid) w_next = ArbAccess;
      end
      ArbAccess: begin
        w_next     = ArbResp;
        ram_ce_o   = ~rst;
        ram_we_o   = ~rst & r_we;
        ram_addr_o = rst ? '0 : r_addr;
        ram_data_o = rst ? '0 : r_wdata;
        ram_sel_o  = rst ? '0 : r_sel;
      end
      ArbResp: begin
        w_next = w_valid ? ArbAccess : ArbIdle;
        m0_ack = ~rst & (r_id == MASTER0);
        m1_ack = ~rst & (r_id == MASTER1);
        if (!r_we) begin
          m0_rdata = m0_ack ? ram_data_i : '0;
          m1_rdata = m1_ack ? ram_data_i : '0;
        end
      end
      default: w_next = ArbIdle;
    endcase
  end

  assign m0_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a byte-lane RAM model
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_sel_o(ram_sel_o), .ram_data_i(ram_data_i)
  );

  // Synchronous single-port RAM: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (ram_ce_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
      ram_data_i <= mem[ram_addr_o[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  task automatic wait_ack(input int m, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(tag, 32'd0, 32'd1);
  endtask

  // Scoreboard: each ack pops the oldest expected word for that master.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack) begin
        if (exp0.size() == 0) check("m0_ack_unexpected", 32'd1, 32'd0);
        else check("m0_rdata", m0_rdata, exp0.pop_front());
      end else check("m0_rdata_idle", m0_rdata, 32'd0);
      if (m1_ack) begin
        if (exp1.size() == 0) check("m1_ack_unexpected", 32'd1, 32'd0);
        else check("m1_rdata", m1_rdata, exp1.pop_front());
      end else check("m1_rdata_idle", m1_rdata, 32'd0);
      check("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
    end
  end

  initial begin
    int t0, t_m0, t_m1, n_ack, n_same, last_id;

    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_sel = 4'hF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_sel = 4'hF;

    // Reset held three cycles with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
      check("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
      check("rst_m0_stall", {31'd0, m0_stall}, 32'd1);
      check("rst_ram_ce", {31'd0, ram_ce_o}, 32'd0);
      check("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
      check("rst_ram_addr", ram_addr_o, 32'd0);
      check("rst_ram_data", ram_data_o, 32'd0);
      check("rst_ram_sel", {28'd0, ram_sel_o}, 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Single m0 read.
    preload(6'd4, 32'hDEADBEEF);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF;
    exp0.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("rd_idle_ce", {31'd0, ram_ce_o}, 32'd0);
    check("rd_idle_stall", {31'd0, m0_stall}, 32'd1);
    @(negedge clk);
    check("rd_acc_ce", {31'd0, ram_ce_o}, 32'd1);
    check("rd_acc_we", {31'd0, ram_we_o}, 32'd0);
    check("rd_acc_addr", ram_addr_o, 32'h10);
    check("rd_acc_stall", {31'd0, m0_stall}, 32'd1);
    @(negedge clk);
    check("rd_resp_ack", {31'd0, m0_ack}, 32'd1);
    check("rd_resp_stall", {31'd0, m0_stall}, 32'd0);
    check("rd_resp_ce", {31'd0, ram_ce_o}, 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0;

    // m1 partial write, then m0 reads the merged word back.
    preload(6'd8, 32'hFFFFFFFF);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_sel = 4'b0011;
    exp1.push_back(32'h0);
    wait_ack(1, "wr_m1_ack_timeout");
    @(posedge clk); #1;
    m1_req = 1'b0; m1_we = 1'b0;
    check("wr_mem_merge", mem[8], 32'hFFFF5678);
    m0_req = 1'b1; m0_addr = 32'h20;
    exp0.push_back(32'hFFFF5678);
    wait_ack(0, "rb_m0_ack_timeout");
    @(posedge clk); #1;
    m0_req = 1'b0;

    // Simultaneous requests straight after reset: m0 first, m1 back-to-back.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_addr = 32'h20; m1_sel = 4'hF;
    exp0.push_back(32'hDEADBEEF);
    exp1.push_back(32'hFFFF5678);
    t0 = cyc; t_m0 = -1; t_m1 = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_ack && t_m0 < 0) t_m0 = cyc - t0;
      if (m1_ack && t_m1 < 0) t_m1 = cyc - t0;
      @(posedge clk); #1;
      if (t_m0 >= 0) m0_req = 1'b0;
      if (t_m1 >= 0) m1_req = 1'b0;
    end
    check("sim_m0_lat", t_m0, 32'd2);
    check("sim_m1_lat", t_m1, 32'd4);

    // Continuous contention for twelve cycles must alternate grants.
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp0.push_back(32'hDEADBEEF);
      exp1.push_back(32'hFFFF5678);
    end
    n_ack = 0; n_same = 0; last_id = -1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        n_ack++;
        if ((m0_ack ? 0 : 1) == last_id) n_same++;
        last_id = m0_ack ? 0 : 1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("cont_acks", n_ack, 32'd6);
    check("cont_repeat", n_same, 32'd0);
    check("cont_first_m0", (last_id == 1) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Reset lands on the ACCESS cycle of an m0 write.
    preload(6'd16, 32'h11111111);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hA5A5A5A5; m0_sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ram_we", {31'd0, ram_we_o}, 32'd0);
    check("rstw_ram_ce", {31'd0, ram_ce_o}, 32'd0);
    check("rstw_m0_ack", {31'd0, m0_ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    check("rstw_next_ce", {31'd0, ram_ce_o}, 32'd0);
    check("rstw_next_ack", {31'd0, m0_ack}, 32'd0);
    check("rstw_next_addr", ram_addr_o, 32'd0);
    check("rstw_mem", mem[16], 32'h11111111);
    repeat (3) @(negedge clk);

    check("exp0_left", exp0.size(), 32'd0);
    check("exp1_left", exp1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
